npc_fetch: RTL and testbench

NPC_FETCH -- requirements
Module: npc_fetch

---
 rtl/npc_fetch_if.sv | 21 ++
 rtl/npc_fetch.sv | 105 ++++++++++
 tb/tb_npc_fetch.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_fetch_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and memory (slave).
interface npc_fetch_if;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ready;
  logic [31:0] Imem_Rdata;

  modport master (
    output Imem_Req,
    output Imem_Addr,
    input  Imem_Ready,
    input  Imem_Rdata
  );

  modport slave (
    input  Imem_Req,
    input  Imem_Addr,
    output Imem_Ready,
    output Imem_Rdata
  );
endinterface

// File: rtl/npc_fetch.sv
// Fetch stage with IF/ID register, one-word skid buffer and delayed-branch redirect.
module npc_fetch (
  input  logic               clk,
  input  logic               reset,
  input  logic               Stall_D,
  input  logic               Branch_D,
  input  logic               Equal_D,
  input  logic               Jump_D,
  input  logic               JumpReg_D,
  input  logic [31:0]        RD1_D_R,
  npc_fetch_if.master        imem,
  output logic [31:0]        Instr_D,
  output logic [31:0]        PC_D,
  output logic [31:0]        PC8_D,
  output logic               Valid_D
);

  typedef enum logic [0:0] {StReq, StBuf} state_e;

  state_e      state_q;
  logic [31:0] pc_f_q;
  logic [31:0] instr_d_q;
  logic [31:0] pc_d_q;
  logic        valid_d_q;
  logic        pend_vld_q;
  logic [31:0] pend_tgt_q;
  logic [31:0] buf_q;

  logic        advance;
  logic        accept;
  logic        taken;
  logic        redirect;
  logic [31:0] word;
  logic [31:0] pc_plus4_d;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] target;
  logic [31:0] pc_f_next;

  assign advance  = !Stall_D;
  assign accept   = advance && (((state_q == StReq) && imem.Imem_Ready) || (state_q == StBuf));
  assign word     = (state_q == StBuf) ? buf_q : imem.Imem_Rdata;
  assign taken    = valid_d_q && advance && (JumpReg_D || Jump_D || (Branch_D && Equal_D));
  // A redirect already pending wins over a control instruction seen in its delay slot.
  assign redirect = taken && !pend_vld_q;

  always_comb begin
    pc_plus4_d = pc_d_q + 32'd4;
    br_tgt     = pc_plus4_d + {{14{instr_d_q[15]}}, instr_d_q[15:0], 2'b00};
    j_tgt      = {pc_plus4_d[31:28], instr_d_q[25:0], 2'b00};
    if (JumpReg_D) begin
      target = RD1_D_R;
    end else if (Jump_D) begin
      target = j_tgt;
    end else begin
      target = br_tgt;
    end
    if (redirect) begin
      pc_f_next = target;
    end else if (pend_vld_q) begin
      pc_f_next = pend_tgt_q;
    end else begin
      pc_f_next = pc_f_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StReq;
      pc_f_q     <= 32'h0000_3000;
      instr_d_q  <= 32'h0;
      pc_d_q     <= 32'h0;
      valid_d_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'h0;
      buf_q      <= 32'h0;
    end else if (accept) begin
      instr_d_q  <= word;
      pc_d_q     <= pc_f_q;
      valid_d_q  <= 1'b1;
      state_q    <= StReq;
      pc_f_q     <= pc_f_next;
      pend_vld_q <= 1'b0;
    end else begin
      if (advance) begin
        valid_d_q <= 1'b0;
      end else if ((state_q == StReq) && imem.Imem_Ready) begin
        buf_q   <= imem.Imem_Rdata;
        state_q <= StBuf;
      end
      if (redirect) begin
        pend_tgt_q <= target;
        pend_vld_q <= 1'b1;
      end
    end
  end

  assign imem.Imem_Req  = (state_q == StReq);
  assign imem.Imem_Addr = pc_f_q;
  assign Instr_D        = instr_d_q;
  assign PC_D           = pc_d_q;
  assign PC8_D          = pc_d_q + 32'd8;
  assign Valid_D        = valid_d_q;

endmodule

// File: tb/tb_npc_fetch.sv
// Scoreboard bench: a delayed-branch program model predicts the stream of instructions into D.
module tb_npc_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        Stall_D;
  logic        Branch_D;
  logic        Equal_D;
  logic        Jump_D;
  logic        JumpReg_D;
  logic [31:0] RD1_D_R;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        Valid_D;

  npc_fetch_if bus ();

  npc_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .Stall_D   (Stall_D),
    .Branch_D  (Branch_D),
    .Equal_D   (Equal_D),
    .Jump_D    (Jump_D),
    .JumpReg_D (JumpReg_D),
    .RD1_D_R   (RD1_D_R),
    .imem      (bus),
    .Instr_D   (Instr_D),
    .PC_D      (PC_D),
    .PC8_D     (PC8_D),
    .Valid_D   (Valid_D)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned pops     = 0;
  logic        dir_mode = 1'b0;
  exp_t        q[$];

  logic [31:0] m_pc;
  logic        m_sched_vld;
  logic [31:0] m_sched;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Program image: deterministic function of the address so the model and memory agree.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (dir_mode) return (a == 32'h3000) ? {6'h04, 5'd0, 5'd1, 16'h0004} : {6'h08, a[27:2]};
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    h = h * 32'h85EB_CA6B;
    h = h ^ (h >> 13);
    case (h[3:0])
      4'd0, 4'd1: return {6'h04, 5'd0, 4'd0, h[20], {9{h[12]}}, h[12:6]};
      4'd2:       return {6'h02, 26'h0C00 + 26'(h[31:24])};
      4'd3:       return {6'h00, h[31:22], 10'h0, 6'h08};
      default:    return {6'h08, h[31:6]};
    endcase
  endfunction

  // Register-file value seen by jr: either the 0x3000 region or just below the wrap point.
  function automatic logic [31:0] rd1_of(input logic [31:0] w);
    return w[25] ? 32'hFFFF_FFE0 + {27'h0, w[18:16], 2'b00} : 32'h3000 + {21'h0, w[24:16], 2'b00};
  endfunction

  task automatic model_init();
    m_pc        = 32'h3000;
    m_sched_vld = 1'b0;
    m_sched     = 32'h0;
  endtask

  // Each executed control transfer takes effect after the following (delay-slot) instruction.
  task automatic model_push();
    logic [31:0] w, p4, tgt;
    logic        tk;
    exp_t        e;
    w  = mem_word(m_pc);
    p4 = m_pc + 32'd4;
    tk = 1'b0;
    tgt = 32'h0;
    if (w[31:26] == 6'h00 && w[5:0] == 6'h08) begin
      tk = 1'b1;
      tgt = rd1_of(w);
    end else if (w[31:26] == 6'h02) begin
      tk = 1'b1;
      tgt = {p4[31:28], w[25:0], 2'b00};
    end else if (w[31:26] == 6'h04 && w[16]) begin
      tk = 1'b1;
      tgt = p4 + 32'($signed(w[15:0]) * 4);
    end
    e.pc    = m_pc;
    e.instr = w;
    q.push_back(e);
    m_pc        = m_sched_vld ? m_sched : p4;
    m_sched_vld = tk;
    m_sched     = tgt;
  endtask

  // Drive decode of the D-stage word, hazard stall and memory response for the coming edge.
  task automatic drive(input logic st, input logic rdy);
    Stall_D        = st;
    Branch_D       = (Instr_D[31:26] == 6'h04);
    Equal_D        = Instr_D[16];
    Jump_D         = (Instr_D[31:26] == 6'h02);
    JumpReg_D      = (Instr_D[31:26] == 6'h00) && (Instr_D[5:0] == 6'h08);
    RD1_D_R        = rd1_of(Instr_D);
    bus.Imem_Ready = rdy & bus.Imem_Req;
    bus.Imem_Rdata = bus.Imem_Ready ? mem_word(bus.Imem_Addr) : $urandom;
    while (q.size() < 4) model_push();
  endtask

  task automatic step(input logic st, input logic rdy);
    drive(st, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b1);
    @(posedge clk);
    #1;
    q.delete();
    model_init();
    reset = 1'b0;
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) step($urandom_range(3) == 0, $urandom_range(2) != 0);
  endtask

  // Monitor: classifies each edge and pops the scoreboard whenever a new instruction enters D.
  initial begin
    exp_t e, last;
    logic s, r, last_v;
    last   = '0;
    last_v = 1'b0;
    forever begin
      @(posedge clk);
      s = Stall_D;
      r = reset;
      @(negedge clk);
      if (r) begin
        chk("rst_valid", 32'(Valid_D), 32'h0);
        chk("rst_pc_d", PC_D, 32'h0);
        chk("rst_instr_d", Instr_D, 32'h0);
        chk("rst_req", 32'(bus.Imem_Req), 32'h1);
        chk("rst_addr", bus.Imem_Addr, 32'h3000);
        last = '0;
      end else if (s) begin
        chk("hold_valid", 32'(Valid_D), 32'(last_v));
        chk("hold_pc_d", PC_D, last.pc);
        chk("hold_instr_d", Instr_D, last.instr);
      end else if (Valid_D) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty actual=unexpected_instr pc=%h required=none", PC_D);
        end else begin
          e = q.pop_front();
          pops++;
          chk("d_pc", PC_D, e.pc);
          chk("d_instr", Instr_D, e.instr);
          chk("d_pc8", PC8_D, e.pc + 32'd8);
          last = e;
        end
      end else begin
        chk("bubble_pc_d", PC_D, last.pc);
      end
      last_v = Valid_D;
    end
  end

  initial begin
    reset     = 1'b1;
    Stall_D   = 1'b0;
    Branch_D  = 1'b0;
    Equal_D   = 1'b0;
    Jump_D    = 1'b0;
    JumpReg_D = 1'b0;
    RD1_D_R   = 32'h0;
    bus.Imem_Ready = 1'b0;
    bus.Imem_Rdata = 32'h0;
    model_init();

    do_reset();
    chk("first_addr", bus.Imem_Addr, 32'h3000);
    rand_run(3000);

    // Stall while the fetch returns: word is buffered and consumed without a refetch.
    dir_mode = 1'b1;
    do_reset();
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("buf_req_low", 32'(bus.Imem_Req), 32'h0);
    chk("buf_pc_d_held", PC_D, 32'h3000);
    step(1'b0, 1'b0);
    chk("buf_no_refetch", bus.Imem_Addr, 32'h3014);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Pending redirect plus buffered word, then reset: everything must clear.
    do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("pend_bubble", 32'(Valid_D), 32'h0);
    step(1'b1, 1'b1);
    chk("pend_buf_req_low", 32'(bus.Imem_Req), 32'h0);
    do_reset();
    chk("rst_buf_addr", bus.Imem_Addr, 32'h3000);
    step(1'b0, 1'b1);
    chk("rst_pend_cleared", bus.Imem_Addr, 32'h3004);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    dir_mode = 1'b0;
    do_reset();
    rand_run(2000);

    checks++;
    if (pops < 500) begin
      failures++;
      $display("FAIL throughput actual=%0d instrs required>=500", pops);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
